// File: rtl/wb_uart_bridge_pkg.sv
// Shared definitions for the UART-driven wishbone master bridge:
// FSM state encoding, command signature and response byte codes.
package wb_uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam logic [2:0] CMD_SIG    = 3'b101;

    localparam logic [7:0] RSP_WR_OK  = 8'hA5;
    localparam logic [7:0] RSP_BUS_TO = 8'hEE;
    localparam logic [7:0] RSP_RX_ERR = 8'hEF;

    // A command byte is accepted only with the signature present and at
    // least one byte lane selected.
    function automatic logic cmd_ok(input logic [7:0] b);
        return (b[6:4] == CMD_SIG) && (b[3:0] != 4'h0);
    endfunction

endpackage

// File: rtl/wb_uart_bridge_ser.sv
// uart_byte_ser: holds a 1- or 4-byte response and hands it to the UART
// transmitter MSB first over a valid/ready handshake. done pulses in the
// cycle the last byte is accepted.
module uart_byte_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        load_four,
    input  logic [31:0] load_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  left_q,  left_d;
    logic        valid_q, valid_d;

    // Load a new response, or step to the next byte on each accepted handshake.
    always_comb begin
        shreg_d = shreg_q;
        left_d  = left_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (load) begin
            // A single-byte response sits in the top lane so it goes out first.
            shreg_d = load_four ? load_data : {load_data[7:0], 24'h0};
            left_d  = load_four ? 2'd3 : 2'd0;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready) begin
            if (left_q == 2'd0) begin
                valid_d = 1'b0;
                done    = 1'b1;
            end else begin
                shreg_d = {shreg_q[23:0], 8'h0};
                left_d  = left_q - 2'd1;
            end
        end
    end

    // Serialiser state; reset abandons any byte in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data  = shreg_q[31:24];
    assign tx_valid = valid_q;

endmodule

// File: rtl/wb_uart_bridge.sv
// wb_uart_bridge: wishbone master fed by a UART byte stream. Parses
// cmd/address/data frames, runs one single-beat bus cycle per frame and
// returns a response through uart_byte_ser.
// Optional build macro WB_UART_BRIDGE_RX_TIMEOUT_EN: abandon a partial
// frame silently when the line goes idle for RX_GAP_CYCLES.
module wb_uart_bridge
    import wb_uart_bridge_pkg::*;
#(
    parameter int BUS_TIMEOUT   = 1024,
    parameter int RX_GAP_CYCLES = 1000000,
    parameter int TIMER_WIDTH   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [29:0] wbm_addr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_data_o,
    input  logic [31:0] wbm_data_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    // The shared timer must be able to count to the last cycle of either wait.
    if (BUS_TIMEOUT < 1 || RX_GAP_CYCLES < 1 ||
        longint'(BUS_TIMEOUT)   > (longint'(1) << TIMER_WIDTH) ||
        longint'(RX_GAP_CYCLES) > (longint'(1) << TIMER_WIDTH)) begin : g_bad_timer
        $error("wb_uart_bridge: TIMER_WIDTH too narrow for the configured timeouts");
    end

    localparam logic [TIMER_WIDTH-1:0] BUS_LAST = TIMER_WIDTH'(BUS_TIMEOUT - 1);
`ifdef WB_UART_BRIDGE_RX_TIMEOUT_EN
    localparam logic [TIMER_WIDTH-1:0] GAP_LAST = TIMER_WIDTH'(RX_GAP_CYCLES - 1);
`endif

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q,   cnt_d;
    logic                   we_q,    we_d;
    logic [3:0]             sel_q,   sel_d;
    logic [29:0]            addr_q,  addr_d;
    logic [31:0]            data_q,  data_d;
    logic                   cyc_q,   cyc_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;

    logic        ser_load;
    logic        ser_four;
    logic [31:0] ser_data;
    logic        ser_done;

    // Frame parser, bus sequencer and shared timer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cyc_d    = cyc_q;
        timer_d  = timer_q;
        ser_load = 1'b0;
        ser_four = 1'b0;
        ser_data = 32'h0;

        case (state_q)
            ST_IDLE: begin
                // rx_err alone is ignored here; a flagged byte never starts a frame.
                if (rx_valid && !rx_err && cmd_ok(rx_data)) begin
                    we_d    = rx_data[7];
                    sel_d   = rx_data[3:0];
                    cnt_d   = 2'd0;
                    timer_d = '0;
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR, ST_DATA: begin
                if (rx_err) begin
                    ser_load = 1'b1;
                    ser_data = {24'h0, RSP_RX_ERR};
                    state_d  = ST_RESP;
                end else if (rx_valid) begin
                    timer_d = '0;
                    cnt_d   = cnt_q + 2'd1;
                    if (state_q == ST_ADDR) begin
                        // Only word-address bits [31:2] are kept; the final
                        // byte contributes its upper six bits.
                        addr_d = (cnt_q == 2'd3) ? {addr_q[23:0], rx_data[7:2]}
                                                 : {addr_q[21:0], rx_data};
                    end else begin
                        data_d = {data_q[23:0], rx_data};
                    end
                    if (cnt_q == 2'd3) begin
                        if (state_q == ST_ADDR && we_q) begin
                            state_d = ST_DATA;
                        end else begin
                            cyc_d   = 1'b1;
                            state_d = ST_BUS;
                        end
                    end
                end
`ifdef WB_UART_BRIDGE_RX_TIMEOUT_EN
                else if (timer_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end

            ST_BUS: begin
                // Ack is tested first so an ack on the final timeout cycle succeeds.
                if (wbm_ack_i) begin
                    cyc_d    = 1'b0;
                    ser_load = 1'b1;
                    if (we_q) begin
                        ser_data = {24'h0, RSP_WR_OK};
                    end else begin
                        ser_four = 1'b1;
                        ser_data = wbm_data_i;
                    end
                    state_d = ST_RESP;
                end else if (timer_q == BUS_LAST) begin
                    cyc_d    = 1'b0;
                    ser_load = 1'b1;
                    ser_data = {24'h0, RSP_BUS_TO};
                    state_d  = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Bridge state registers; reset drops cyc/stb immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cyc_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cyc_q   <= cyc_d;
            timer_q <= timer_d;
        end
    end

    uart_byte_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_four (ser_four),
        .load_data (ser_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (ser_done)
    );

    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = we_q;
    assign wbm_addr_o = addr_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_data_o = data_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
